local_history_table_param: RTL and testbench
============================================

Name: local_history_table_param

Overview:
- Parametrised per-branch local history table for the tournament predictor; successor to the fixed 10-bit / 1024-entry table.
- Indexes entries by PC slice, returns the stored history combinationally for the local prediction stage.
- Shifts resolved branch outcomes in through an explicit update port rather than an internal PC delay line.
- Adds a self-clearing FSM after reset and on flush, a ready flag, and an update-drop counter.

Parameters:
- HIST_W, 10, history bits per entry.
- ENTRIES, 1024, table depth; power of two, >= 2.
- IDX_LSB, 0, lowest PC bit used for the index; index = pc[IDX_LSB +: $clog2(ENTRIES)].
- PC_W, 32, PC width.
- CNT_W, 16, width of the dropped-update counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clock).
- flush  in  1  synchronous request to clear the whole table.
- lookup_pc  in  PC_W  fetch PC to look up.
- lookup_hist  out  HIST_W  history of the indexed entry; combinational.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- ready  out  1  table usable; 0 while clearing.
- drop_count  out  CNT_W  updates discarded while not ready.

Behaviour:
- States: CLEAR, RUN. Internal clear index clr_idx, $clog2(ENTRIES) bits.
- Reset (reset==0 at a clock edge):
  - state<=CLEAR, clr_idx<=0, ready<=0, drop_count<=0.
  - Table contents are not touched by reset itself; the CLEAR walk zeroes them.
  - Reset has priority over flush and update.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx, then clr_idx<=clr_idx+1.
  - On the cycle clr_idx==ENTRIES-1: state<=RUN, ready<=1 on the following edge.
  - A full clear takes exactly ENTRIES cycles from the first CLEAR cycle.
- RUN, upd_valid=1: entry[upd_idx] <= {upd_taken, entry[upd_idx][HIST_W-1:1]} (new outcome enters the MSB; oldest bit drops from the LSB). Write is visible on the next cycle.
- flush=1 in RUN: state<=CLEAR, clr_idx<=0, ready<=0 next edge; any update in the same cycle is dropped and counted.
- flush=1 in CLEAR: restarts the walk at clr_idx=0.
- upd_valid=1 while ready==0, or on a flush cycle: update is discarded and drop_count increments. drop_count saturates at all-ones and does not wrap.
- lookup_hist:
  - Combinational read of entry[lookup_idx].
  - Forced to 0 while ready==0, so a partially cleared table is never exposed.
  - Without bypass, a same-cycle update to the same index is not reflected; old value shown.
- Upper PC bits above the index slice are ignored (aliasing is intended).
- When HIST_W==1, the update writes upd_taken only.

Optional Feature:
- Macro LHT_BYPASS_EN.
- Defined: when ready==1, upd_valid==1, flush==0 and upd_idx==lookup_idx, lookup_hist returns the shifted new value in the same cycle (write-to-read forwarding).
- Not defined: lookup_hist always returns the stored pre-update value. No bypass logic is synthesised.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, release -> ready=0 for exactly 1024 cycles, then ready=1; lookup_hist=0 for any PC; drop_count=0.
- Shift pattern: after ready, upd_pc=1234 (idx 210) with taken 1,0,1 on consecutive cycles -> lookup_pc=1234 reads 10'h200, 10'h100, 10'h280 on the cycles after each update.
- Aliasing: update upd_pc=210 taken=1 -> lookup_pc=1234 reads 10'h200 (same idx); lookup_pc=211 reads 0.
- Saturation of history: eleven consecutive taken updates to idx 5 -> 10'h3FF. Then one not-taken -> 10'h1FF.
- Flush mid-run: entry 5 = 10'h3FF, assert flush with upd_valid=1 -> drop_count=1, ready=0 for 1024 cycles, then entry 5 reads 0. Updates during the clear each increment drop_count.
- Bypass: with LHT_BYPASS_EN, lookup_pc=upd_pc=7, entry 7 = 0, taken=1 -> lookup_hist=10'h200 same cycle. Without the macro -> 0 that cycle, 10'h200 next cycle.

Source files
------------

// File: rtl/local_history_table_param.sv
// Parametrised per-branch local history table for the tournament predictor.
// PC-sliced index, combinational lookup, explicit resolved-branch update port,
// self-clearing walk after reset/flush, ready flag and saturating drop counter.
// Optional feature: define LHT_BYPASS_EN for same-cycle write-to-read forwarding.
module local_history_table_param #(
    parameter int unsigned HIST_W  = 10,
    parameter int unsigned ENTRIES = 1024,
    parameter int unsigned IDX_LSB = 0,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic [HIST_W-1:0] lookup_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    output logic              ready,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int unsigned      IDX_W    = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   clr_idx, clr_idx_next;
    logic               ready_next;
    logic [CNT_W-1:0]   drop_next;

    logic [HIST_W-1:0]  hist_mem [ENTRIES];

    logic [IDX_W-1:0]   lookup_idx;
    logic [IDX_W-1:0]   upd_idx;
    logic [HIST_W-1:0]  upd_new;
    logic               upd_drop;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [HIST_W-1:0]  wr_data;

    // Bits outside the index slice are intentionally ignored (aliasing).
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    assign lookup_idx = lookup_pc[IDX_LSB +: IDX_W];
    assign upd_idx    = upd_pc[IDX_LSB +: IDX_W];

    // New outcome enters the MSB, oldest bit falls off the LSB (HIST_W==1 keeps only the outcome).
    assign upd_new = (hist_mem[upd_idx] >> 1) | (HIST_W'(upd_taken) << (HIST_W - 1));

    // Next-state, clear walk, update write selection and drop accounting.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        ready_next   = ready;
        drop_next    = drop_count;
        wr_en        = 1'b0;
        wr_idx       = upd_idx;
        wr_data      = upd_new;
        upd_drop     = upd_valid && (!ready || flush);

        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = clr_idx;
                wr_data = '0;
                if (flush) begin
                    clr_idx_next = '0;
                end else if (clr_idx == LAST_IDX) begin
                    state_next   = RUN;
                    ready_next   = 1'b1;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx + IDX_W'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                    ready_next   = 1'b0;
                end else if (upd_valid && ready) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = '0;
                ready_next   = 1'b0;
            end
        endcase

        if (upd_drop && (drop_count != CNT_MAX)) begin
            drop_next = drop_count + CNT_W'(1);
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            ready      <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            clr_idx    <= clr_idx_next;
            ready      <= ready_next;
            drop_count <= drop_next;
        end
    end

    // History storage; reset itself leaves contents alone, the clear walk zeroes them.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            hist_mem[wr_idx] <= wr_data;
        end
    end

`ifdef LHT_BYPASS_EN
    logic byp_hit;
    assign byp_hit = ready && upd_valid && !flush && (upd_idx == lookup_idx);

    // Lookup with forwarding of a same-cycle update to the same entry; hidden while clearing.
    assign lookup_hist = !ready ? '0 : (byp_hit ? upd_new : hist_mem[lookup_idx]);
`else
    // Lookup of the stored value; hidden while clearing.
    assign lookup_hist = ready ? hist_mem[lookup_idx] : '0;
`endif

endmodule

// File: tb/tb_local_history_table_param.sv
// Scoreboard bench for local_history_table_param: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor pops and checks.
module tb_local_history_table_param;

    localparam int unsigned HIST_W  = 10;
    localparam int unsigned ENTRIES = 1024;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 3;

    localparam int K_HIST  = 0;
    localparam int K_READY = 1;
    localparam int K_DROP  = 2;

    logic              clock;
    logic              reset;
    logic              flush;
    logic [PC_W-1:0]   lookup_pc;
    logic [HIST_W-1:0] lookup_hist;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic              ready;
    logic [CNT_W-1:0]  drop_count;

    local_history_table_param #(
        .HIST_W (HIST_W),
        .ENTRIES(ENTRIES),
        .IDX_LSB(0),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .lookup_pc  (lookup_pc),
        .lookup_hist(lookup_hist),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .ready      (ready),
        .drop_count (drop_count)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_HIST:  return "lookup_hist";
            K_READY: return "ready";
            default: return "drop_count";
        endcase
    endfunction

    // Same-cycle value seen for an update to the looked-up entry.
    function automatic logic [31:0] same_cycle(input logic [31:0] newv, input logic [31:0] oldv);
`ifdef LHT_BYPASS_EN
        return newv;
`else
        return oldv;
`endif
    endfunction

    task automatic expect_now(input int kind, input logic [31:0] value);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = value;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] pc, input logic t);
        upd_valid = v;
        upd_pc    = pc;
        upd_taken = t;
    endtask

    // Monitor: compare every expectation due in this cycle against the DUT.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_HIST:  act = 32'(lookup_hist);
                K_READY: act = 32'(ready);
                default: act = 32'(drop_count);
            endcase
            n_checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (due %0d): got %h expected %h",
                         kname(e.kind), cyc, e.cyc, act, e.exp);
            end
        end
    end

    logic [HIST_W-1:0] sat_tbl [12] = '{10'h000, 10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0,
                                        10'h3F0, 10'h3F8, 10'h3FC, 10'h3FE, 10'h3FF, 10'h3FF};

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        lookup_pc = '0;
        drive_upd(1'b0, 32'd0, 1'b0);

        // Reset for one edge, then the 1024-cycle clear walk.
        step();
        reset = 1'b1;
        lookup_pc = 32'd1234;
        expect_now(K_DROP, 0);
        expect_now(K_HIST, 0);
        for (int i = 0; i < ENTRIES; i++) begin
            expect_now(K_READY, 0);
            step();
        end
        expect_now(K_READY, 1);
        expect_now(K_HIST, 0);
        expect_now(K_DROP, 0);
        step();

        // Shift pattern on idx 210.
        drive_upd(1'b1, 32'd1234, 1'b1);
        expect_now(K_HIST, same_cycle(32'h200, 32'h000));
        step();
        drive_upd(1'b1, 32'd1234, 1'b0);
        expect_now(K_HIST, same_cycle(32'h100, 32'h200));
        step();
        drive_upd(1'b1, 32'd1234, 1'b1);
        expect_now(K_HIST, same_cycle(32'h280, 32'h100));
        step();
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_HIST, 32'h280);
        step();

        // Aliasing: pc 300 and pc 1324 share idx 300; neighbour 301 untouched.
        drive_upd(1'b1, 32'd300, 1'b1);
        lookup_pc = 32'd1324;
        expect_now(K_HIST, same_cycle(32'h200, 32'h000));
        step();
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_HIST, 32'h200);
        step();
        lookup_pc = 32'd301;
        expect_now(K_HIST, 0);
        step();

        // History saturation: eleven taken then one not-taken on idx 5.
        lookup_pc = 32'd5;
        for (int k = 0; k < 11; k++) begin
            drive_upd(1'b1, 32'd5, 1'b1);
            expect_now(K_HIST, same_cycle(32'(sat_tbl[k+1]), 32'(sat_tbl[k])));
            step();
        end
        drive_upd(1'b1, 32'd5, 1'b0);
        expect_now(K_HIST, same_cycle(32'h1FF, 32'h3FF));
        step();
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_HIST, 32'h1FF);
        expect_now(K_DROP, 0);
        step();

        // Flush with a same-cycle update: update dropped, no forwarding on a flush cycle.
        flush = 1'b1;
        drive_upd(1'b1, 32'd5, 1'b1);
        expect_now(K_HIST, 32'h1FF);
        expect_now(K_READY, 1);
        expect_now(K_DROP, 0);
        step();
        flush = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            drive_upd(i < 3, 32'd5, 1'b1);
            expect_now(K_READY, 0);
            expect_now(K_DROP, 32'(1 + ((i < 3) ? i : 3)));
            if (i < 4) expect_now(K_HIST, 0);
            step();
        end
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_READY, 1);
        expect_now(K_DROP, 4);
        expect_now(K_HIST, 0);
        step();

        // Flush again, restart the walk mid-clear, drop counter saturates at 7.
        flush = 1'b1;
        drive_upd(1'b1, 32'd9, 1'b1);
        expect_now(K_DROP, 4);
        step();
        for (int i = 0; i < 1125; i++) begin
            flush = (i == 100);
            drive_upd(1'b1, 32'd9, 1'b1);
            expect_now(K_READY, 0);
            expect_now(K_DROP, 32'((5 + i > 7) ? 7 : 5 + i));
            step();
        end
        flush = 1'b0;
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_READY, 1);
        expect_now(K_DROP, 7);
        expect_now(K_HIST, 0);
        step();

        // Reset has priority over a concurrent update and clears the counter.
        reset = 1'b0;
        drive_upd(1'b1, 32'd5, 1'b1);
        step();
        reset = 1'b1;
        drive_upd(1'b0, 32'd0, 1'b0);
        expect_now(K_READY, 0);
        expect_now(K_DROP, 0);
        expect_now(K_HIST, 0);
        step();

        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
